// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the parametrised register file.
// Provides the zero-register index and a packed-vector port slicer.
package regfile_pkg;

    localparam int DEF_DATA_W  = 64;
    localparam int DEF_ADDR_W  = 5;
    localparam int XZR_IDX     = 31;
    localparam int MAX_PORTS   = 4;
    localparam int MAX_SLICE_W = 128;
    localparam int MAX_PACK_W  = MAX_PORTS * MAX_SLICE_W;

    // Extracts port p's w-bit slice from a packed per-port vector (zero-extended to MAX_PACK_W).
    function automatic logic [MAX_SLICE_W-1:0] port_slice(
        input logic [MAX_PACK_W-1:0] vec,
        input int                    p,
        input int                    w
    );
        logic [MAX_PACK_W-1:0]  shifted_s;
        logic [MAX_SLICE_W-1:0] mask_s;
        shifted_s  = vec >> (p * w);
        mask_s     = (MAX_SLICE_W'(1) << w) - MAX_SLICE_W'(1);
        port_slice = shifted_s[MAX_SLICE_W-1:0] & mask_s;
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: index select, zero-register override,
// same-cycle write bypass and busy masking.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_EN  = 1,
    parameter int ZERO_IDX = XZR_IDX,
    parameter int BYPASS   = 1
) (
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
    input  logic [(2**ADDR_W)-1:0]             busy,
    input  logic [ADDR_W-1:0]                  addr,
    input  logic                               write,
    input  logic [ADDR_W-1:0]                  wr_addr,
    input  logic [DATA_W-1:0]                  wr_data,
    input  logic                               reserve,
    input  logic [ADDR_W-1:0]                  res_addr,
    output logic [DATA_W-1:0]                  data,
    output logic                               data_busy
);

    logic zero_hit_s;
    logic bypass_hit_s;

    assign zero_hit_s   = (ZERO_EN != 0) && (addr == ADDR_W'(ZERO_IDX));
    assign bypass_hit_s = (BYPASS != 0) && write && (wr_addr == addr);

    // Zero register dominates; a forwarded write stays busy only if re-reserved this cycle.
    always_comb begin
        data      = regs[addr];
        data_busy = busy[addr];
        if (zero_hit_s) begin
            data      = '0;
            data_busy = 1'b0;
        end else if (bypass_hit_s) begin
            data      = wr_data;
            data_busy = reserve && (res_addr == addr);
        end else begin
            data      = regs[addr];
            data_busy = busy[addr];
        end
    end

endmodule

// File: rtl/registerfile_param.sv
// Parametrised register file with hardwired zero register, optional write
// bypass and a per-register busy scoreboard for pending writebacks.
module registerfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_EN  = 1,
    parameter int ZERO_IDX = XZR_IDX,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       write,
    input  logic [ADDR_W-1:0]          wrAddr,
    input  logic [DATA_W-1:0]          wrData,
    input  logic                       reserve,
    input  logic [ADDR_W-1:0]          resAddr,
    input  logic [NUM_RD*ADDR_W-1:0]   rdAddr,
    output logic [NUM_RD*DATA_W-1:0]   rdData,
    output logic [NUM_RD-1:0]          rdBusy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem_r;
    logic [DEPTH-1:0]             busy_r;
    logic                         wr_ok_s;
    logic                         res_ok_s;

    assign wr_ok_s  = write   && !((ZERO_EN != 0) && (wrAddr  == ADDR_W'(ZERO_IDX)));
    assign res_ok_s = reserve && !((ZERO_EN != 0) && (resAddr == ADDR_W'(ZERO_IDX)));

    // Storage and scoreboard update; reserve is applied last so it wins over a completing write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_r  <= '0;
            busy_r <= '0;
        end else begin
            if (wr_ok_s) begin
                mem_r[wrAddr]  <= wrData;
                busy_r[wrAddr] <= 1'b0;
            end
            if (res_ok_s) begin
                busy_r[resAddr] <= 1'b1;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        logic [DATA_W-1:0] data_s;
        logic              busy_s;

        assign addr_s = ADDR_W'(port_slice(MAX_PACK_W'(rdAddr), p, ADDR_W));

        regfile_rdport #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_EN  (ZERO_EN),
            .ZERO_IDX (ZERO_IDX),
            .BYPASS   (BYPASS)
        ) u_rdport (
            .regs      (mem_r),
            .busy      (busy_r),
            .addr      (addr_s),
            .write     (write),
            .wr_addr   (wrAddr),
            .wr_data   (wrData),
            .reserve   (reserve),
            .res_addr  (resAddr),
            .data      (data_s),
            .data_busy (busy_s)
        );

        assign rdData[p*DATA_W +: DATA_W] = data_s;
        assign rdBusy[p]                  = busy_s;
    end

endmodule

// File: tb/tb_registerfile_param.sv
// Directed bench for registerfile_param: default (bypass), no-bypass and
// four-read-port instances share the write/reserve/reset stimulus.
module tb_registerfile_param;

    logic         clk;
    logic         reset;
    logic         write;
    logic [4:0]   wrAddr;
    logic [63:0]  wrData;
    logic         reserve;
    logic [4:0]   resAddr;
    logic [9:0]   rdAddr;
    logic [19:0]  rdAddr4;
    logic [127:0] rdData;
    logic [127:0] rdData_nb;
    logic [255:0] rdData4;
    logic [1:0]   rdBusy;
    logic [1:0]   rdBusy_nb;
    logic [3:0]   rdBusy4;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    registerfile_param dut (
        .clk(clk), .reset(reset), .write(write), .wrAddr(wrAddr), .wrData(wrData),
        .reserve(reserve), .resAddr(resAddr), .rdAddr(rdAddr),
        .rdData(rdData), .rdBusy(rdBusy)
    );

    registerfile_param #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .write(write), .wrAddr(wrAddr), .wrData(wrData),
        .reserve(reserve), .resAddr(resAddr), .rdAddr(rdAddr),
        .rdData(rdData_nb), .rdBusy(rdBusy_nb)
    );

    registerfile_param #(.NUM_RD(4)) dut4 (
        .clk(clk), .reset(reset), .write(write), .wrAddr(wrAddr), .wrData(wrData),
        .reserve(reserve), .resAddr(resAddr), .rdAddr(rdAddr4),
        .rdData(rdData4), .rdBusy(rdBusy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge (one rising edge passes in between).
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic rd(input logic [4:0] a, input logic [4:0] b);
        rdAddr = {b, a};
        #1;
    endtask

    initial begin
        reset   = 1'b0;
        write   = 1'b0;
        wrAddr  = 5'd0;
        wrData  = 64'd0;
        reserve = 1'b0;
        resAddr = 5'd0;
        rdAddr  = 10'd0;
        rdAddr4 = 20'd0;
        cyc();
        cyc();
        reset = 1'b1;

        // After reset every register reads 0 and idle on both ports.
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i));
            chk($sformatf("rst_dataA_r%0d", i), rdData[63:0], 64'd0);
            chk($sformatf("rst_dataB_r%0d", 31 - i), rdData[127:64], 64'd0);
            chk($sformatf("rst_busy_r%0d", i), {62'd0, rdBusy}, 64'd0);
        end

        // Write one-hot values to R0..R5.
        for (int i = 0; i < 6; i++) begin
            write  = 1'b1;
            wrAddr = 5'(i);
            wrData = 64'd1 << i;
            cyc();
        end
        write = 1'b0;
        rd(5'd0, 5'd1);
        chk("rdA_r0", rdData[63:0], 64'h1);
        chk("rdB_r1", rdData[127:64], 64'h2);
        rd(5'd2, 5'd3);
        chk("rdA_r2", rdData[63:0], 64'h4);
        chk("rdB_r3", rdData[127:64], 64'h8);
        rd(5'd4, 5'd5);
        chk("rdA_r4", rdData[63:0], 64'h10);
        chk("rdB_r5", rdData[127:64], 64'h20);
        chk("nb_rdB_r5", rdData_nb[127:64], 64'h20);

        // Four ports on distinct registers at once.
        rdAddr4 = {5'd4, 5'd3, 5'd2, 5'd1};
        #1;
        chk("p4_port0", rdData4[63:0], 64'h2);
        chk("p4_port1", rdData4[127:64], 64'h4);
        chk("p4_port2", rdData4[191:128], 64'h8);
        chk("p4_port3", rdData4[255:192], 64'h10);

        // Zero register: writes ignored, no bypass, reserve ignored.
        write  = 1'b1;
        wrAddr = 5'd31;
        wrData = ONES;
        rd(5'd31, 5'd31);
        chk("xzr_nobypass", rdData[63:0], 64'd0);
        cyc();
        write = 1'b0;
        rd(5'd31, 5'd0);
        chk("xzr_data", rdData[63:0], 64'd0);
        reserve = 1'b1;
        resAddr = 5'd31;
        cyc();
        reserve = 1'b0;
        #1;
        chk("xzr_busy", {63'd0, rdBusy[0]}, 64'd0);

        // Same-cycle write to R0 while port A reads R0.
        write  = 1'b1;
        wrAddr = 5'd0;
        wrData = ONES;
        rd(5'd0, 5'd1);
        chk("byp_data", rdData[63:0], ONES);
        chk("byp_busy", {63'd0, rdBusy[0]}, 64'd0);
        chk("nb_old_data", rdData_nb[63:0], 64'h1);
        chk("byp_portB_unaffected", rdData[127:64], 64'h2);
        cyc();
        write = 1'b0;
        #1;
        chk("nb_new_data", rdData_nb[63:0], ONES);
        chk("byp_stored", rdData[63:0], ONES);

        // Reserve R7: busy visible only after the edge.
        reserve = 1'b1;
        resAddr = 5'd7;
        rd(5'd7, 5'd6);
        chk("res_same_cycle", {63'd0, rdBusy[0]}, 64'd0);
        cyc();
        reserve = 1'b0;
        #1;
        chk("res_busy", {63'd0, rdBusy[0]}, 64'd1);
        chk("res_other_idle", {63'd0, rdBusy[1]}, 64'd0);
        cyc();
        cyc();
        #1;
        chk("res_busy_held", {63'd0, rdBusy_nb[0]}, 64'd1);
        write  = 1'b1;
        wrAddr = 5'd7;
        wrData = 64'h55;
        #1;
        chk("wb_byp_data", rdData[63:0], 64'h55);
        chk("wb_byp_busy", {63'd0, rdBusy[0]}, 64'd0);
        chk("wb_nb_busy", {63'd0, rdBusy_nb[0]}, 64'd1);
        cyc();
        write = 1'b0;
        #1;
        chk("wb_busy_clear", {63'd0, rdBusy[0]}, 64'd0);
        chk("wb_nb_busy_clear", {63'd0, rdBusy_nb[0]}, 64'd0);
        chk("wb_data", rdData_nb[63:0], 64'h55);

        // Write and reserve R7 on the same edge: reserve wins.
        write   = 1'b1;
        wrAddr  = 5'd7;
        wrData  = 64'h66;
        reserve = 1'b1;
        resAddr = 5'd7;
        #1;
        chk("wr_res_byp_data", rdData[63:0], 64'h66);
        chk("wr_res_byp_busy", {63'd0, rdBusy[0]}, 64'd1);
        cyc();
        write   = 1'b0;
        reserve = 1'b0;
        #1;
        chk("wr_res_busy", {63'd0, rdBusy[0]}, 64'd1);
        chk("wr_res_data", rdData[63:0], 64'h66);

        // Reset overrides a concurrent write and clears busy.
        reset  = 1'b0;
        write  = 1'b1;
        wrAddr = 5'd3;
        wrData = 64'hAB;
        cyc();
        reset = 1'b1;
        write = 1'b0;
        rd(5'd3, 5'd7);
        chk("rstwr_r3", rdData_nb[63:0], 64'd0);
        chk("rst_r7_data", rdData[127:64], 64'd0);
        chk("rst_r7_busy", {63'd0, rdBusy[1]}, 64'd0);
        rd(5'd0, 5'd5);
        chk("rst_r0", rdData[63:0], 64'd0);
        chk("rst_r5", rdData[127:64], 64'd0);

        // First write after reset lands on the first edge with reset high.
        write  = 1'b1;
        wrAddr = 5'd3;
        wrData = 64'hCD;
        cyc();
        write = 1'b0;
        rd(5'd3, 5'd3);
        chk("post_rst_wr", rdData_nb[63:0], 64'hCD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
